// File: rtl/pool4_result_sender.sv
// Layer-4 result sender: packs requantized pooled samples into 16-byte rows,
// strobes each row with maxflagin and pulses done4 after ROWS rows.
// Build option: define POOL4_SAT_EN to saturate narrowed samples to [-128, 127];
// otherwise the low 8 bits of the shifted value are kept.
module pool4_result_sender #(
   parameter int CH    = 16,
   parameter int ROWS  = 4,
   parameter int SHIFT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        pool_valid,
   input  logic [15:0] pool_data,
   output logic [7:0]  out41,
   output logic [7:0]  out42,
   output logic [7:0]  out43,
   output logic [7:0]  out44,
   output logic [7:0]  out45,
   output logic [7:0]  out46,
   output logic [7:0]  out47,
   output logic [7:0]  out48,
   output logic [7:0]  out49,
   output logic [7:0]  out410,
   output logic [7:0]  out411,
   output logic [7:0]  out412,
   output logic [7:0]  out413,
   output logic [7:0]  out414,
   output logic [7:0]  out415,
   output logic [7:0]  out416,
   output logic        maxflagin,
   output logic        done4,
   output logic        busy,
   output logic        drop_err
);

   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [3:0]             ch_cnt_q, ch_cnt_d;
   logic [RW-1:0]          row_cnt_q, row_cnt_d;
   logic [CH-1:0][7:0]     fill_q, fill_d;
   logic [CH-1:0][7:0]     lane_q, lane_d;
   logic                   maxflag_q, maxflag_d;
   logic                   done4_q, done4_d;
   logic                   busy_q, busy_d;
   logic                   drop_q, drop_d;
   logic                   start_ok_s;
   logic                   row_end_s;
   logic [7:0]             narrow_s;

   function automatic logic [7:0] narrow(input logic [15:0] x);
`ifdef POOL4_SAT_EN
      logic signed [15:0] sh;
      sh = $signed(x) >>> SHIFT;
      if (sh > 16'sd127) begin
         return 8'h7F;
      end else if (sh < -16'sd128) begin
         return 8'h80;
      end else begin
         return sh[7:0];
      end
`else
      return 8'($signed(x) >>> SHIFT);
`endif
   endfunction

   // A start seen while done4 is still high belongs to the finished run and is ignored.
   assign start_ok_s = start && !done4_q;
   assign row_end_s  = (state_q == S_COLLECT) && pool_valid && (ch_cnt_q == 4'(CH - 1));
   assign narrow_s   = narrow(pool_data);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start_ok_s) state_d = S_COLLECT;
            else            state_d = S_IDLE;
         end
         S_COLLECT: begin
            if (row_end_s && (row_cnt_q == RW'(ROWS - 1))) state_d = S_DONE;
            else                                            state_d = S_COLLECT;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      ch_cnt_d  = ch_cnt_q;
      row_cnt_d = row_cnt_q;
      fill_d    = fill_q;
      lane_d    = lane_q;
      maxflag_d = 1'b0;
      drop_d    = drop_q;
      done4_d   = (state_q == S_DONE);
      case (state_q)
         S_IDLE: begin
            if (start_ok_s) begin
               ch_cnt_d  = 4'd0;
               row_cnt_d = '0;
            end else begin
               ch_cnt_d  = ch_cnt_q;
            end
            // A sample arriving with start is still discarded and keeps the error flag.
            drop_d = pool_valid | (drop_q & ~start_ok_s);
         end
         S_COLLECT: begin
            if (pool_valid) begin
               fill_d[ch_cnt_q] = narrow_s;
               if (ch_cnt_q == 4'(CH - 1)) begin
                  lane_d    = fill_d;
                  maxflag_d = 1'b1;
                  ch_cnt_d  = 4'd0;
                  row_cnt_d = row_cnt_q + RW'(1);
               end else begin
                  ch_cnt_d  = ch_cnt_q + 4'd1;
               end
            end else begin
               ch_cnt_d = ch_cnt_q;
            end
         end
         S_DONE: begin
            drop_d = drop_q | pool_valid;
         end
         default: begin
            drop_d = drop_q;
         end
      endcase
      busy_d = (state_d != S_IDLE) || done4_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ch_cnt_q  <= 4'd0;
         row_cnt_q <= '0;
         fill_q    <= '0;
         lane_q    <= '0;
         maxflag_q <= 1'b0;
         done4_q   <= 1'b0;
         busy_q    <= 1'b0;
         drop_q    <= 1'b0;
      end else begin
         ch_cnt_q  <= ch_cnt_d;
         row_cnt_q <= row_cnt_d;
         fill_q    <= fill_d;
         lane_q    <= lane_d;
         maxflag_q <= maxflag_d;
         done4_q   <= done4_d;
         busy_q    <= busy_d;
         drop_q    <= drop_d;
      end
   end

   assign out41     = lane_q[0];
   assign out42     = lane_q[1];
   assign out43     = lane_q[2];
   assign out44     = lane_q[3];
   assign out45     = lane_q[4];
   assign out46     = lane_q[5];
   assign out47     = lane_q[6];
   assign out48     = lane_q[7];
   assign out49     = lane_q[8];
   assign out410    = lane_q[9];
   assign out411    = lane_q[10];
   assign out412    = lane_q[11];
   assign out413    = lane_q[12];
   assign out414    = lane_q[13];
   assign out415    = lane_q[14];
   assign out416    = lane_q[15];
   assign maxflagin = maxflag_q;
   assign done4     = done4_q;
   assign busy      = busy_q;
   assign drop_err  = drop_q;

endmodule
